pc_stack_unit: RTL and testbench

- Program-counter and hardware call-stack block of the FRANK6000 datapath. It is the consumer end of the control bus.
- It receives the jump, jump-mode, call, return and PC-write strobes produced each cycle by the control unit, together with the decoded branch target.
- It maintains the PC that addresses program memory, plus a small circular return-address stack for CALLS/RETRN.
- The PC output feeds program-memory address decode. The stack status outputs feed debug/status logic.

---
 rtl/pc_stack_unit.sv | 116 +++++++++++
 tb/tb_pc_stack_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pc_stack_unit.sv
// Program counter and circular return-address stack for the FRANK6000 datapath.
// CALLS pushes PC+1 and loads the target in one edge; RETRN pops into the return register first.
module pc_stack_unit #(
    parameter int PC_W        = 10,
    parameter int STACK_DEPTH = 4,
    parameter int SP_W        = $clog2(STACK_DEPTH)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_en,
    input  logic            i_jump,
    input  logic [1:0]      i_j_mode,
    input  logic            i_call,
    input  logic            i_return,
    input  logic            i_PCw,
    input  logic [PC_W-1:0] i_target,
    output logic [PC_W-1:0] o_pc,
    output logic [PC_W-1:0] o_ret_addr,
    output logic [SP_W:0]   o_stack_count,
    output logic            o_stack_empty,
    output logic            o_stack_full,
    output logic            o_stack_ovf,
    output logic            o_stack_unf
);

    localparam logic [SP_W:0] DEPTH_CNT = (SP_W + 1)'(STACK_DEPTH);

    logic [PC_W-1:0] pc_reg;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] ret_reg;
    logic [PC_W-1:0] mem_reg [STACK_DEPTH];
    logic [SP_W-1:0] sp_reg;
    logic [SP_W-1:0] sp_dec;
    logic [SP_W:0]   count_reg;
    logic            ovf_reg;
    logic            unf_reg;
    logic            push;
    logic            pop;
    logic            empty;
    logic            full;

    // A simultaneous call strobe always suppresses the return strobe.
    assign push   = i_en & i_call & i_jump & i_PCw;
    assign pop    = i_en & i_return & ~i_call;
    assign empty  = (count_reg == '0);
    assign full   = (count_reg == DEPTH_CNT);
    assign pc_inc = pc_reg + 1'b1;
    assign sp_dec = sp_reg - 1'b1;

    always_comb begin
        pc_next = pc_inc;
        if (i_jump) begin
            case (i_j_mode)
                2'b00:   pc_next = pc_inc;
                2'b01:   pc_next = i_target;
                2'b10:   pc_next = ret_reg;
                default: pc_next = pc_reg + PC_W'(2);
            endcase
        end
    end

    // Each entry captures PC+1 when the pointer sits on it; when full this overwrites the oldest.
    generate
        for (genvar gi = 0; gi < STACK_DEPTH; gi++) begin : g_entry
            always_ff @(posedge i_clk) begin
                if (!i_rst) begin
                    mem_reg[gi] <= '0;
                end else if (push && (sp_reg == SP_W'(gi))) begin
                    mem_reg[gi] <= pc_inc;
                end
            end
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            pc_reg    <= '0;
            ret_reg   <= '0;
            sp_reg    <= '0;
            count_reg <= '0;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
        end else if (i_en) begin
            if (i_PCw) begin
                pc_reg <= pc_next;
            end
            if (push) begin
                sp_reg <= sp_reg + 1'b1;
                if (full) begin
                    ovf_reg <= 1'b1;
                end else begin
                    count_reg <= count_reg + 1'b1;
                end
            end else if (pop) begin
                if (empty) begin
                    ret_reg <= '0;
                    unf_reg <= 1'b1;
                end else begin
                    ret_reg   <= mem_reg[sp_dec];
                    sp_reg    <= sp_dec;
                    count_reg <= count_reg - 1'b1;
                end
            end
        end
    end

    assign o_pc          = pc_reg;
    assign o_ret_addr    = ret_reg;
    assign o_stack_count = count_reg;
    assign o_stack_empty = empty;
    assign o_stack_full  = full;
    assign o_stack_ovf   = ovf_reg;
    assign o_stack_unf   = unf_reg;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed vector table plus randomized run against a queue-based stack model.
module tb_pc_stack_unit;

    localparam int PC_W  = 10;
    localparam int DEPTH = 4;
    localparam int SP_W  = 2;

    logic            clk = 1'b0;
    logic            rst, en, jump, call, ret, pcw;
    logic [1:0]      mode;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] pc, ret_addr;
    logic [SP_W:0]   count;
    logic            empty, full, ovf, unf;

    always #5 clk = ~clk;

    pc_stack_unit #(.PC_W(PC_W), .STACK_DEPTH(DEPTH), .SP_W(SP_W)) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_jump(jump), .i_j_mode(mode),
        .i_call(call), .i_return(ret), .i_PCw(pcw), .i_target(target),
        .o_pc(pc), .o_ret_addr(ret_addr), .o_stack_count(count),
        .o_stack_empty(empty), .o_stack_full(full),
        .o_stack_ovf(ovf), .o_stack_unf(unf)
    );

    typedef struct {
        logic       rst, en, jump, call, ret, pcw;
        logic [1:0] mode;
        logic [9:0] target;
        logic [9:0] e_pc, e_ret;
        int         e_cnt;
        logic       e_ovf, e_unf;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Behavioural model: a bounded LIFO of return addresses.
    logic [9:0] m_pc, m_ret;
    logic [9:0] m_stack[$];
    logic       m_ovf, m_unf;

    task automatic add(input logic r, e, j, input logic [1:0] md, input logic c, rt, w,
                       input logic [9:0] tg, ep, er, input int ec, input logic eo, eu);
        vec_t v;
        v.rst = r; v.en = e; v.jump = j; v.mode = md; v.call = c; v.ret = rt; v.pcw = w;
        v.target = tg; v.e_pc = ep; v.e_ret = er; v.e_cnt = ec; v.e_ovf = eo; v.e_unf = eu;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [9:0] old_pc, old_ret;
        old_pc  = m_pc;
        old_ret = m_ret;
        if (!rst) begin
            m_pc = '0; m_ret = '0; m_stack.delete(); m_ovf = 0; m_unf = 0;
        end else if (en) begin
            if (call && jump && pcw) begin
                m_stack.push_back(old_pc + 10'd1);
                if (m_stack.size() > DEPTH) begin
                    void'(m_stack.pop_front());
                    m_ovf = 1;
                end
            end else if (ret && !call) begin
                if (m_stack.size() > 0) m_ret = m_stack.pop_back();
                else begin
                    m_ret = '0;
                    m_unf = 1;
                end
            end
            if (pcw) begin
                if (!jump || mode == 2'd0) m_pc = old_pc + 10'd1;
                else if (mode == 2'd1)     m_pc = target;
                else if (mode == 2'd2)     m_pc = old_ret;
                else                       m_pc = old_pc + 10'd2;
            end
        end
    endtask

    task automatic drive_edge(input logic r, e, j, input logic [1:0] md, input logic c, rt, w,
                              input logic [9:0] tg);
        rst = r; en = e; jump = j; mode = md; call = c; ret = rt; pcw = w; target = tg;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [9:0] ep, er, input int ec,
                             input logic eo, eu);
        check({tag, " pc"}, int'(pc), int'(ep));
        check({tag, " ret"}, int'(ret_addr), int'(er));
        check({tag, " count"}, int'(count), ec);
        check({tag, " empty"}, int'(empty), int'(ec == 0));
        check({tag, " full"}, int'(full), int'(ec == DEPTH));
        check({tag, " ovf"}, int'(ovf), int'(eo));
        check({tag, " unf"}, int'(unf), int'(eu));
    endtask

    initial begin
        logic [9:0] p;
        m_pc = '0; m_ret = '0; m_ovf = 0; m_unf = 0;
        rst = 0; en = 0; jump = 0; mode = 0; call = 0; ret = 0; pcw = 0; target = '0;

        // rst en jmp mode call ret pcw target | pc ret cnt ovf unf
        add(0,0,0,2'd0,0,0,0,10'h000, 10'h000,10'h000,0,0,0);
        for (int i = 1; i <= 5; i++) add(1,1,0,2'd0,0,0,1,10'h000, 10'(i),10'h000,0,0,0);
        add(1,1,1,2'd1,0,0,1,10'h3F0, 10'h3F0,10'h000,0,0,0);
        p = 10'h3F0;
        for (int i = 0; i < 8; i++) begin
            p = p + 10'd2;
            add(1,1,1,2'd3,0,0,1,10'h000, p,10'h000,0,0,0);
        end
        add(1,1,1,2'd1,0,0,1,10'h010, 10'h010,10'h000,0,0,0);
        add(1,1,1,2'd1,1,0,1,10'h200, 10'h200,10'h000,1,0,0);
        add(1,1,0,2'd0,0,0,1,10'h000, 10'h201,10'h000,1,0,0);
        add(1,1,0,2'd0,0,0,1,10'h000, 10'h202,10'h000,1,0,0);
        add(1,1,0,2'd0,0,1,0,10'h000, 10'h202,10'h011,0,0,0);
        add(1,1,1,2'd2,0,0,1,10'h000, 10'h011,10'h011,0,0,0);
        add(1,1,1,2'd1,0,0,1,10'h000, 10'h000,10'h011,0,0,0);
        add(1,1,1,2'd1,1,0,1,10'h100, 10'h100,10'h011,1,0,0);
        add(1,1,1,2'd1,1,0,1,10'h101, 10'h101,10'h011,2,0,0);
        add(1,1,1,2'd1,1,0,1,10'h102, 10'h102,10'h011,3,0,0);
        add(1,1,1,2'd1,1,0,1,10'h103, 10'h103,10'h011,4,0,0);
        add(1,1,1,2'd1,1,0,1,10'h104, 10'h104,10'h011,4,1,0);
        add(1,1,0,2'd0,0,1,0,10'h000, 10'h104,10'h104,3,1,0);
        add(1,1,0,2'd0,0,1,0,10'h000, 10'h104,10'h103,2,1,0);
        add(1,1,0,2'd0,0,1,0,10'h000, 10'h104,10'h102,1,1,0);
        add(1,1,0,2'd0,0,1,0,10'h000, 10'h104,10'h101,0,1,0);
        add(1,1,0,2'd0,0,1,0,10'h000, 10'h104,10'h000,0,1,1);
        add(1,1,1,2'd1,0,0,1,10'h020, 10'h020,10'h000,0,1,1);
        add(1,1,1,2'd1,1,1,1,10'h300, 10'h300,10'h000,1,1,1);
        add(1,0,1,2'd1,1,0,1,10'h055, 10'h300,10'h000,1,1,1);
        add(1,1,0,2'd0,0,1,0,10'h000, 10'h300,10'h021,0,1,1);
        add(1,1,1,2'd1,1,0,1,10'h050, 10'h050,10'h021,1,1,1);
        add(1,1,0,2'd0,0,1,0,10'h000, 10'h050,10'h301,0,1,1);
        add(0,1,1,2'd2,0,0,1,10'h000, 10'h000,10'h000,0,0,0);
        add(1,1,1,2'd1,1,0,1,10'h080, 10'h080,10'h000,1,0,0);
        add(1,1,1,2'd2,0,1,1,10'h000, 10'h000,10'h001,0,0,0);

        @(negedge clk);
        foreach (vecs[i]) begin
            drive_edge(vecs[i].rst, vecs[i].en, vecs[i].jump, vecs[i].mode,
                       vecs[i].call, vecs[i].ret, vecs[i].pcw, vecs[i].target);
            check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_ret,
                      vecs[i].e_cnt, vecs[i].e_ovf, vecs[i].e_unf);
            $display("vec %0d: pc=%03h ret=%03h count=%0d ovf=%0b unf=%0b",
                     i, pc, ret_addr, count, ovf, unf);
        end

        for (int i = 0; i < 600; i++) begin
            drive_edge(($urandom_range(0, 79) != 0), ($urandom_range(0, 7) != 0),
                       1'($urandom), 2'($urandom), ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
                       10'($urandom));
            check_all($sformatf("rnd%0d", i), m_pc, m_ret, m_stack.size(), m_ovf, m_unf);
            $display("rnd %0d: pc=%03h ret=%03h count=%0d ovf=%0b unf=%0b",
                     i, pc, ret_addr, count, ovf, unf);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
